// File: rtl/shot_tracker.sv
// Shot record for the opponent board: debounced fire button, hit/miss judging
// against a static ship map, running counts, and a registered per-pixel lookup.
module shot_tracker #(
  parameter int GRID_SIZE   = 10,
  parameter int CELL_WIDTH  = 64,
  parameter int CELL_HEIGHT = 48,
  parameter int GRID_LEFT   = 144,
  parameter int GRID_TOP    = 35,
  parameter int SHIP_CELLS  = 17,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             btn_c,
  input  logic [3:0]                       cursor_row,
  input  logic [3:0]                       cursor_col,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]   ship_map,
  input  logic                             bright,
  input  logic [9:0]                       hCount,
  input  logic [9:0]                       vCount,
  output logic                             in_grid,
  output logic [1:0]                       cell_state,
  output logic                             shot_valid,
  output logic                             shot_hit,
  output logic                             shot_repeat,
  output logic [6:0]                       shots_count,
  output logic [6:0]                       hits_count,
  output logic                             game_over
);

  localparam int          CELLS      = GRID_SIZE * GRID_SIZE;
  localparam int          CELL_SHIFT = $clog2(CELL_WIDTH);
  localparam logic [9:0]  H_LO       = 10'(GRID_LEFT);
  localparam logic [9:0]  H_HI       = 10'(GRID_LEFT + GRID_SIZE * CELL_WIDTH);
  localparam logic [9:0]  V_LO       = 10'(GRID_TOP);
  localparam logic [9:0]  V_HI       = 10'(GRID_TOP + GRID_SIZE * CELL_HEIGHT);
  localparam logic [6:0]  SHIP_TOTAL = 7'(SHIP_CELLS);
  localparam logic [6:0]  COUNT_MAX  = 7'(CELLS);

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE, OVER} state_t;

  logic [SAMPLE_BITS-1:0] sampleCnt_q;
  logic [2:0]             history_q;
  logic                   debounced_q;
  logic                   prev_q;
  logic                   tick;
  logic                   firePulse;

  state_t                 state_q;
  logic [6:0]             idx_q;
  logic [CELLS-1:0]       shotBits_q;
  logic [CELLS-1:0]       hitBits_q;
  logic [6:0]             shots_q;
  logic [6:0]             hits_q;
  logic                   shotValid_q;
  logic                   shotHit_q;
  logic                   shotRepeat_q;
  logic                   gameOver_q;

  logic                   inGrid_d, inGrid_q;
  logic [1:0]             cellState_d, cellState_q;
  logic [3:0]             pixRow;
  logic [3:0]             pixCol;
  logic [6:0]             pixIdx;

  assign tick      = (sampleCnt_q == '0);
  assign firePulse = debounced_q & ~prev_q & tick;

  // Debounced level only moves on sample ticks, so a press yields one pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sampleCnt_q <= '0;
      history_q   <= '0;
      debounced_q <= 1'b0;
      prev_q      <= 1'b0;
    end else begin
      sampleCnt_q <= sampleCnt_q + 1'b1;
      if (tick) begin
        history_q   <= {history_q[1:0], btn_c};
        debounced_q <= &{history_q[1:0], btn_c};
        prev_q      <= debounced_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shotBits_q   <= '0;
      hitBits_q    <= '0;
      shots_q      <= '0;
      hits_q       <= '0;
      shotValid_q  <= 1'b0;
      shotHit_q    <= 1'b0;
      shotRepeat_q <= 1'b0;
      gameOver_q   <= 1'b0;
    end else begin
      shotValid_q  <= 1'b0;
      shotHit_q    <= 1'b0;
      shotRepeat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (firePulse && cursor_row < 4'(GRID_SIZE) && cursor_col < 4'(GRID_SIZE)) begin
            idx_q   <= 7'(cursor_row) * 7'(GRID_SIZE) + 7'(cursor_col);
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (shotBits_q[idx_q]) begin
            shotRepeat_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          shotBits_q[idx_q] <= 1'b1;
          hitBits_q[idx_q]  <= ship_map[idx_q];
          shotValid_q       <= 1'b1;
          shotHit_q         <= ship_map[idx_q];
          if (shots_q < COUNT_MAX) shots_q <= shots_q + 7'd1;
          if (ship_map[idx_q] && hits_q < COUNT_MAX) hits_q <= hits_q + 7'd1;
          if (ship_map[idx_q] && (hits_q + 7'd1 == SHIP_TOTAL)) begin
            gameOver_q <= 1'b1;
            state_q    <= OVER;
          end else begin
            state_q <= IDLE;
          end
        end
        OVER: begin
          gameOver_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Row comes from a boundary comparator chain since the cell height is not a power of two.
  always_comb begin
    inGrid_d = bright && (hCount >= H_LO) && (hCount < H_HI) &&
               (vCount >= V_LO) && (vCount < V_HI);
    pixCol   = 4'((hCount - H_LO) >> CELL_SHIFT);
    pixRow   = '0;
    for (int k = 1; k < GRID_SIZE; k++) begin
      if (vCount >= 10'(GRID_TOP + k * CELL_HEIGHT)) pixRow = pixRow + 4'd1;
    end
    pixIdx      = 7'(pixRow) * 7'(GRID_SIZE) + 7'(pixCol);
    cellState_d = 2'b00;
    if (inGrid_d) begin
      if (hitBits_q[pixIdx])       cellState_d = 2'b10;
      else if (shotBits_q[pixIdx]) cellState_d = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inGrid_q    <= 1'b0;
      cellState_q <= 2'b00;
    end else begin
      inGrid_q    <= inGrid_d;
      cellState_q <= cellState_d;
    end
  end

  assign in_grid     = inGrid_q;
  assign cell_state  = cellState_q;
  assign shot_valid  = shotValid_q;
  assign shot_hit    = shotHit_q;
  assign shot_repeat = shotRepeat_q;
  assign shots_count = shots_q;
  assign hits_count  = hits_q;
  assign game_over   = gameOver_q;

endmodule

// File: tb/tb_shot_tracker.sv
// Directed bench for shot_tracker with a short debounce period (SAMPLE_BITS = 4).
module tb_shot_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_c = 1'b0;
  logic [3:0]  cursor_row = '0;
  logic [3:0]  cursor_col = '0;
  logic [99:0] shipMap = '0;
  logic        bright = 1'b0;
  logic [9:0]  hCount = '0;
  logic [9:0]  vCount = '0;
  logic        in_grid;
  logic [1:0]  cell_state;
  logic        shot_valid, shot_hit, shot_repeat, game_over;
  logic [6:0]  shots_count, hits_count;

  int nAssert = 0;
  int nFail = 0;
  int validSeen = 0;
  int repeatSeen = 0;
  logic lastHit = 1'b0;
  logic goAtValid = 1'b0;

  shot_tracker #(.SAMPLE_BITS(4)) dut (
    .clk(clk), .reset(reset), .btn_c(btn_c),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .ship_map(shipMap),
    .bright(bright), .hCount(hCount), .vCount(vCount),
    .in_grid(in_grid), .cell_state(cell_state),
    .shot_valid(shot_valid), .shot_hit(shot_hit), .shot_repeat(shot_repeat),
    .shots_count(shots_count), .hits_count(hits_count), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Pulse outputs are tallied here so tasks can compare before/after deltas.
  always @(negedge clk) begin
    if (shot_valid) begin
      validSeen = validSeen + 1;
      lastHit   = shot_hit;
      goAtValid = game_over;
    end
    if (shot_repeat) repeatSeen = repeatSeen + 1;
  end

  task automatic doReset();
    reset = 1'b1;
    btn_c = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic fire(input int row, input int col);
    cursor_row = 4'(row);
    cursor_col = 4'(col);
    btn_c = 1'b1;
    repeat (80) @(negedge clk);
    btn_c = 1'b0;
    repeat (80) @(negedge clk);
  endtask

  task automatic lookup(input int h, input int v, input logic b);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = b;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hCount = 10'd144; vCount = 10'd35; bright = 1'b1;
    repeat (2) @(negedge clk);
    nAssert++;
    if ({in_grid, cell_state, shot_valid, shot_hit, shot_repeat, game_over} !== 7'b0 ||
        shots_count !== 7'd0 || hits_count !== 7'd0) begin
      $display("[TB] FAIL reset_outputs: got grid=%b cell=%b v=%b h=%b r=%b go=%b shots=%0d hits=%0d, expected all 0",
               in_grid, cell_state, shot_valid, shot_hit, shot_repeat, game_over, shots_count, hits_count);
      nFail++;
    end
    reset = 1'b0;
    @(negedge clk);
    nAssert++;
    if (in_grid !== 1'b1 || cell_state !== 2'b00) begin
      $display("[TB] FAIL reset_lookup: got grid=%b cell=%b, expected 1/00", in_grid, cell_state);
      nFail++;
    end
  endtask

  task automatic test_hit();
    int v0 = validSeen;
    doReset();
    shipMap = '0;
    shipMap[23] = 1'b1;
    fire(2, 3);
    nAssert++;
    if (validSeen - v0 !== 1 || lastHit !== 1'b1) begin
      $display("[TB] FAIL hit_pulse: got %0d valids hit=%b, expected 1 valid hit=1", validSeen - v0, lastHit);
      nFail++;
    end
    nAssert++;
    if (shots_count !== 7'd1 || hits_count !== 7'd1) begin
      $display("[TB] FAIL hit_counts: got %0d/%0d, expected 1/1", shots_count, hits_count);
      nFail++;
    end
    lookup(341, 136, 1'b1);
    nAssert++;
    if (in_grid !== 1'b1 || cell_state !== 2'b10) begin
      $display("[TB] FAIL hit_lookup: got grid=%b cell=%b, expected 1/10", in_grid, cell_state);
      nFail++;
    end
  endtask

  task automatic test_miss_repeat();
    int v0, r0;
    doReset();
    shipMap = '0;
    shipMap[23] = 1'b1;
    v0 = validSeen; r0 = repeatSeen;
    fire(0, 0);
    nAssert++;
    if (validSeen - v0 !== 1 || lastHit !== 1'b0 || shots_count !== 7'd1 || hits_count !== 7'd0) begin
      $display("[TB] FAIL miss: got valids=%0d hit=%b counts=%0d/%0d, expected 1/0 and 1/0",
               validSeen - v0, lastHit, shots_count, hits_count);
      nFail++;
    end
    lookup(144, 35, 1'b1);
    nAssert++;
    if (in_grid !== 1'b1 || cell_state !== 2'b01) begin
      $display("[TB] FAIL miss_lookup: got grid=%b cell=%b, expected 1/01", in_grid, cell_state);
      nFail++;
    end
    v0 = validSeen;
    fire(0, 0);
    nAssert++;
    if (repeatSeen - r0 !== 1 || validSeen - v0 !== 0 || shots_count !== 7'd1 || hits_count !== 7'd0) begin
      $display("[TB] FAIL repeat: got repeats=%0d valids=%0d counts=%0d/%0d, expected 1/0 and 1/0",
               repeatSeen - r0, validSeen - v0, shots_count, hits_count);
      nFail++;
    end
    v0 = validSeen; r0 = repeatSeen;
    fire(10, 0);
    nAssert++;
    if (repeatSeen - r0 !== 0 || validSeen - v0 !== 0 || shots_count !== 7'd1) begin
      $display("[TB] FAIL out_of_range: got repeats=%0d valids=%0d shots=%0d, expected 0/0/1",
               repeatSeen - r0, validSeen - v0, shots_count);
      nFail++;
    end
  endtask

  task automatic test_lookup_edges();
    lookup(143, 35, 1'b1);
    nAssert++;
    if (in_grid !== 1'b0 || cell_state !== 2'b00) begin
      $display("[TB] FAIL left_edge: got grid=%b cell=%b, expected 0/00", in_grid, cell_state);
      nFail++;
    end
    lookup(783, 514, 1'b1);
    nAssert++;
    if (in_grid !== 1'b1 || cell_state !== 2'b00) begin
      $display("[TB] FAIL last_pixel: got grid=%b cell=%b, expected 1/00", in_grid, cell_state);
      nFail++;
    end
    lookup(784, 514, 1'b1);
    nAssert++;
    if (in_grid !== 1'b0) begin
      $display("[TB] FAIL right_edge: got grid=%b, expected 0", in_grid);
      nFail++;
    end
    lookup(144, 35, 1'b0);
    nAssert++;
    if (in_grid !== 1'b0 || cell_state !== 2'b00) begin
      $display("[TB] FAIL not_bright: got grid=%b cell=%b, expected 0/00", in_grid, cell_state);
      nFail++;
    end
  endtask

  task automatic test_bounce();
    int v0 = validSeen;
    int s0 = shots_count;
    cursor_row = 4'd7; cursor_col = 4'd7;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) btn_c = ~btn_c;
      @(negedge clk);
    end
    btn_c = 1'b0;
    repeat (80) @(negedge clk);
    nAssert++;
    if (validSeen - v0 !== 0 || shots_count !== 7'(s0)) begin
      $display("[TB] FAIL bounce: got valids=%0d shots=%0d, expected 0 and %0d", validSeen - v0, shots_count, s0);
      nFail++;
    end
  endtask

  task automatic test_game_over();
    int v0, r0;
    doReset();
    shipMap = '0;
    shipMap[16:0] = 17'h1FFFF;
    for (int i = 0; i < 16; i++) fire(i / 10, i % 10);
    nAssert++;
    if (game_over !== 1'b0 || hits_count !== 7'd16) begin
      $display("[TB] FAIL pre_over: got go=%b hits=%0d, expected 0/16", game_over, hits_count);
      nFail++;
    end
    fire(1, 6);
    nAssert++;
    if (game_over !== 1'b1 || goAtValid !== 1'b1 || hits_count !== 7'd17 || shots_count !== 7'd17) begin
      $display("[TB] FAIL game_over: got go=%b goAtValid=%b counts=%0d/%0d, expected 1/1 17/17",
               game_over, goAtValid, shots_count, hits_count);
      nFail++;
    end
    v0 = validSeen; r0 = repeatSeen;
    fire(5, 0);
    nAssert++;
    if (validSeen - v0 !== 0 || repeatSeen - r0 !== 0 || shots_count !== 7'd17 || game_over !== 1'b1) begin
      $display("[TB] FAIL over_ignore: got valids=%0d repeats=%0d shots=%0d go=%b, expected 0/0/17/1",
               validSeen - v0, repeatSeen - r0, shots_count, game_over);
      nFail++;
    end
  endtask

  task automatic test_mid_shot_reset();
    int v0;
    logic seen = 1'b0;
    doReset();
    shipMap = '0;
    fire(4, 4);
    v0 = validSeen;
    cursor_row = 4'd5; cursor_col = 4'd5;
    btn_c = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (dut.firePulse) seen = 1'b1;
    end
    nAssert++;
    if (!seen) begin
      $display("[TB] FAIL mid_shot_wait: got no fire pulse within 200 cycles, expected one");
      nFail++;
    end
    @(negedge clk);
    reset = 1'b1;
    btn_c = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    nAssert++;
    if (validSeen - v0 !== 0 || shots_count !== 7'd0 || hits_count !== 7'd0) begin
      $display("[TB] FAIL mid_shot_reset: got valids=%0d counts=%0d/%0d, expected 0 and 0/0",
               validSeen - v0, shots_count, hits_count);
      nFail++;
    end
    lookup(144 + 4 * 64, 35 + 4 * 48, 1'b1);
    nAssert++;
    if (cell_state !== 2'b00) begin
      $display("[TB] FAIL mid_shot_cleared: got cell=%b, expected 00", cell_state);
      nFail++;
    end
    fire(5, 5);
    nAssert++;
    if (validSeen - v0 !== 1 || shots_count !== 7'd1) begin
      $display("[TB] FAIL after_reset_fire: got valids=%0d shots=%0d, expected 1/1", validSeen - v0, shots_count);
      nFail++;
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_repeat();
    test_lookup_edges();
    test_bounce();
    test_game_over();
    test_mid_shot_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
